// File: rtl/tiger_ckpt_ctrl.sv
// Checkpoint/rollback sequencer for the Tiger MIPS core on intermittent power.
// Saves and restores the register file through an NV store, triggered periodically or by a supply warning.
module tiger_ckpt_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int PERIOD_W     = 16,
  parameter int DRAIN_CYCLES = 4,
  localparam int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] interval,
  input  logic                powerWarn,
  input  logic                powerGood,
  input  logic                nvValid,
  input  logic                iStall,
  input  logic                dStall,
  input  logic                nvAck,
  output logic                checkpoint,
  output logic                checkpointing,
  output logic                zstall,
  output logic                checkpointdone,
  output logic                poweroff,
  output logic [1:0]          poweron,
  output logic                nvWrite,
  output logic                nvRead,
  output logic [IDX_W-1:0]    regIdx,
  output logic                nvCommit,
  output logic                busy
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SAVE,
    S_COMMIT,
    S_OFF,
    S_RESTORE,
    S_RESUME
  } state_t;

  typedef struct packed {
    logic       checkpoint;
    logic       checkpointing;
    logic       zstall;
    logic       checkpointdone;
    logic       poweroff;
    logic [1:0] poweron;
    logic       nv_write;
    logic       nv_read;
    logic       nv_commit;
    logic       busy;
  } ctrl_t;

  state_t              state;
  state_t              state_nxt;
  ctrl_t               ctrl;
  logic [PERIOD_W-1:0] int_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [IDX_W-1:0]    reg_idx;
  logic                warn_latched;

  logic period_hit;
  logic stall;
  logic drain_last;
  logic idx_last;

  assign period_hit = (interval != '0) && (int_cnt == interval - PERIOD_W'(1));
  assign stall      = iStall | dStall;
  assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));
  assign idx_last   = (reg_idx == IDX_W'(NUM_REGS - 1));

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    unique case (s)
      S_DRAIN:   begin c.checkpoint = 1'b1; c.zstall = 1'b1; end
      S_SAVE:    begin
        c.checkpoint    = 1'b1;
        c.checkpointing = 1'b1;
        c.zstall        = 1'b1;
        c.nv_write      = 1'b1;
      end
      S_COMMIT:  begin
        c.checkpoint     = 1'b1;
        c.zstall         = 1'b1;
        c.checkpointdone = 1'b1;
        c.nv_commit      = 1'b1;
      end
      S_OFF:     begin c.poweroff = 1'b1; c.zstall = 1'b1; end
      S_RESTORE: begin c.poweron = 2'b01; c.zstall = 1'b1; c.nv_read = 1'b1; end
      S_RESUME:  c.poweron = 2'b10;
      default:   ;
    endcase
    return c;
  endfunction

  // NOTE: state_nxt gets a default before the case so no latch is inferred on unlisted paths.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (powerWarn || period_hit) state_nxt = S_DRAIN;
      S_DRAIN:   if (!stall && drain_last) state_nxt = S_SAVE;
      S_SAVE:    if (nvAck && idx_last) state_nxt = S_COMMIT;
      S_COMMIT:  state_nxt = warn_latched ? S_OFF : S_IDLE;
      S_OFF:     if (powerGood && !powerWarn) state_nxt = nvValid ? S_RESTORE : S_RESUME;
      S_RESTORE: begin
        if (powerWarn)                 state_nxt = S_OFF;
        else if (nvAck && idx_last)    state_nxt = S_RESUME;
      end
      S_RESUME:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they always equal the decode of the current state.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ctrl         <= '0;
      int_cnt      <= '0;
      drain_cnt    <= '0;
      reg_idx      <= '0;
      warn_latched <= 1'b0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
      unique case (state)
        S_IDLE: begin
          drain_cnt <= '0;
          if (powerWarn)       warn_latched <= 1'b1;
          else if (period_hit) int_cnt      <= '0;
          else                 int_cnt      <= int_cnt + PERIOD_W'(1);
        end
        S_DRAIN: begin
          if (powerWarn) warn_latched <= 1'b1;
          if (stall || drain_last) drain_cnt <= '0;
          else                     drain_cnt <= drain_cnt + DRAIN_W'(1);
          if (!stall && drain_last) reg_idx <= '0;
        end
        S_SAVE: begin
          if (powerWarn) warn_latched <= 1'b1;
          if (nvAck)     reg_idx      <= idx_last ? '0 : reg_idx + IDX_W'(1);
        end
        S_COMMIT: int_cnt <= '0;
        S_OFF: begin
          if (state_nxt != S_OFF) begin
            warn_latched <= 1'b0;
            reg_idx      <= '0;
          end
        end
        S_RESTORE: begin
          // An aborted restore leaves the committed NV image as it was; only the index is dropped.
          if (powerWarn)  reg_idx <= '0;
          else if (nvAck) reg_idx <= idx_last ? '0 : reg_idx + IDX_W'(1);
        end
        S_RESUME: int_cnt <= '0;
        default:  ;
      endcase
    end
  end

  assign checkpoint     = ctrl.checkpoint;
  assign checkpointing  = ctrl.checkpointing;
  assign zstall         = ctrl.zstall;
  assign checkpointdone = ctrl.checkpointdone;
  assign poweroff       = ctrl.poweroff;
  assign poweron        = ctrl.poweron;
  assign nvWrite        = ctrl.nv_write;
  assign nvRead         = ctrl.nv_read;
  assign nvCommit       = ctrl.nv_commit;
  assign busy           = ctrl.busy;
  assign regIdx         = reg_idx;

endmodule

// File: tb/tb_tiger_ckpt_ctrl.sv
// Self-checking bench for tiger_ckpt_ctrl: directed scenarios plus random traffic,
// every cycle compared against a phase-level reference model.
module tb_tiger_ckpt_ctrl;

  localparam int NUM_REGS     = 32;
  localparam int PERIOD_W     = 16;
  localparam int DRAIN_CYCLES = 4;
  localparam int IW           = $clog2(NUM_REGS);
  localparam int VW           = 11 + IW;

  localparam int P_RUN = 0, P_DRAIN = 1, P_SAVE = 2, P_COMMIT = 3,
                 P_OFF = 4, P_RESTORE = 5, P_RESUME = 6;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [PERIOD_W-1:0] interval = '0;
  logic                powerWarn = 1'b0, powerGood = 1'b0, nvValid = 1'b0;
  logic                iStall = 1'b0, dStall = 1'b0, nvAck = 1'b0;
  logic                checkpoint, checkpointing, zstall, checkpointdone, poweroff;
  logic [1:0]          poweron;
  logic                nvWrite, nvRead, nvCommit, busy;
  logic [IW-1:0]       regIdx;

  int n_assert = 0, n_fail = 0, n_edge = 0, n_commit = 0, n_read = 0;

  // Reference model state
  int m_ph, m_int, m_drain, m_idx;
  bit m_warn;

  // Scenario bookkeeping
  int rise1, rise2, done1, walk_len, seq_bad, r, s, k, last_idx, n01, n10;
  int base_cnt, prev_idx;
  bit prev_c, prev_d, prev_ack, prev_saving;

  tiger_ckpt_ctrl #(
    .NUM_REGS(NUM_REGS), .PERIOD_W(PERIOD_W), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .interval(interval), .powerWarn(powerWarn),
    .powerGood(powerGood), .nvValid(nvValid), .iStall(iStall), .dStall(dStall),
    .nvAck(nvAck), .checkpoint(checkpoint), .checkpointing(checkpointing),
    .zstall(zstall), .checkpointdone(checkpointdone), .poweroff(poweroff),
    .poweron(poweron), .nvWrite(nvWrite), .nvRead(nvRead), .regIdx(regIdx),
    .nvCommit(nvCommit), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ph = P_RUN; m_int = 0; m_drain = 0; m_idx = 0; m_warn = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs applied for this cycle.
  task automatic model_edge();
    if (reset) begin
      model_clear();
      return;
    end
    case (m_ph)
      P_RUN: begin
        if (powerWarn) begin
          m_warn = 1; m_drain = 0; m_ph = P_DRAIN;
        end else if (interval != 0 && m_int == int'(interval) - 1) begin
          m_int = 0; m_drain = 0; m_ph = P_DRAIN;
        end else begin
          m_int = (m_int + 1) % (1 << PERIOD_W);
        end
      end
      P_DRAIN: begin
        if (powerWarn) m_warn = 1;
        m_drain = (iStall || dStall) ? 0 : m_drain + 1;
        if (m_drain == DRAIN_CYCLES) begin m_idx = 0; m_ph = P_SAVE; end
      end
      P_SAVE: begin
        if (powerWarn) m_warn = 1;
        if (nvAck) begin
          if (m_idx == NUM_REGS - 1) begin m_idx = 0; m_ph = P_COMMIT; end
          else m_idx++;
        end
      end
      P_COMMIT: begin
        m_int = 0;
        m_ph  = m_warn ? P_OFF : P_RUN;
      end
      P_OFF: begin
        if (powerGood && !powerWarn) begin
          m_warn = 0; m_idx = 0;
          m_ph   = nvValid ? P_RESTORE : P_RESUME;
        end
      end
      P_RESTORE: begin
        if (powerWarn) begin m_idx = 0; m_ph = P_OFF; end
        else if (nvAck) begin
          if (m_idx == NUM_REGS - 1) begin m_idx = 0; m_ph = P_RESUME; end
          else m_idx++;
        end
      end
      default: begin m_int = 0; m_ph = P_RUN; end
    endcase
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {checkpoint, checkpointing, zstall, checkpointdone, poweroff, poweron,
            nvWrite, nvRead, nvCommit, busy, regIdx};
  endfunction

  // Field order: checkpoint, checkpointing, zstall, done, poweroff, poweron[1:0], wr, rd, commit, busy
  function automatic logic [VW-1:0] exp_vec();
    logic [10:0] f;
    logic [IW-1:0] idx;
    f   = '0;
    idx = IW'(m_idx);
    case (m_ph)
      P_DRAIN:   f = 11'b1_0_1_0_0_00_0_0_0_1;
      P_SAVE:    f = 11'b1_1_1_0_0_00_1_0_0_1;
      P_COMMIT:  f = 11'b1_0_1_1_0_00_0_0_1_1;
      P_OFF:     f = 11'b0_0_1_0_1_00_0_0_0_1;
      P_RESTORE: f = 11'b0_0_1_0_0_01_0_1_0_1;
      P_RESUME:  f = 11'b0_0_0_0_0_10_0_0_0_1;
      default:   f = '0;
    endcase
    return {f, idx};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    n_edge++;
    if (nvCommit) n_commit++;
    if (nvRead)   n_read++;
    check($sformatf("cycle_%0d", n_edge), obs_vec(), exp_vec());
  endtask

  task automatic wait_idle(string tag, int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin step(); c++; end
    check(tag, busy, 0);
  endtask

  initial begin
    model_clear();

    // Reset state
    repeat (2) step();
    check("reset_outputs_zero", obs_vec(), '0);

    // Periodic checkpoint, interval 100, no stalls, nvAck tied high
    interval = 100; nvAck = 1'b1; reset = 1'b0; n_edge = 0;
    rise1 = -1; rise2 = -1; done1 = -1; walk_len = 0; seq_bad = 0;
    for (int i = 0; i < 400 && rise2 < 0; i++) begin
      prev_c = checkpoint; prev_d = checkpointdone;
      step();
      if (checkpoint && !prev_c) begin
        if (rise1 < 0) rise1 = n_edge; else rise2 = n_edge;
      end
      if (checkpointdone && !prev_d && done1 < 0) done1 = n_edge;
      if (checkpointing && rise2 < 0) begin
        if (int'(regIdx) != walk_len) seq_bad++;
        walk_len++;
      end
    end
    check("periodic_first_rise", rise1, 100);
    // 38 cycles counted inclusively from the trigger cycle (one before checkpoint rises) to the commit cycle
    check("periodic_done_latency", done1, rise1 + (1 + DRAIN_CYCLES + NUM_REGS + 1) - 2);
    check("periodic_next_rise", rise2, done1 + 1 + 100);
    check("save_walk_length", walk_len, NUM_REGS);
    check("save_walk_order", seq_bad, 0);
    interval = 10;
    wait_idle("periodic_back_idle", 60);

    // Drain with two stall cycles
    k = 0;
    while (!checkpoint && k < 30) begin step(); k++; end
    check("drain_trigger_seen", checkpoint, 1);
    r = n_edge; interval = 0;
    step();
    dStall = 1'b1; step(); step();
    dStall = 1'b0;
    k = 0;
    while (!checkpointing && k < 20) begin step(); k++; end
    s = n_edge;
    check("drain_stall_delay", s - r, 1 + 2 + DRAIN_CYCLES);
    wait_idle("drain_back_idle", 60);

    // Warning mid-save, then warm restore
    interval = 5;
    k = 0;
    while (!checkpoint && k < 20) begin step(); k++; end
    interval = 0;
    k = 0;
    while (!(checkpointing && regIdx == 10) && k < 50) begin step(); k++; end
    check("warn_at_idx10", regIdx, 10);
    powerWarn = 1'b1;
    repeat (3) step();
    powerWarn = 1'b0;
    last_idx = -1; k = 0;
    while (!checkpointdone && k < 40) begin
      step();
      if (checkpointing) last_idx = regIdx;
      k++;
    end
    check("warn_save_done_pulse", checkpointdone, 1);
    check("warn_save_reaches_last", last_idx, NUM_REGS - 1);
    step();
    check("warn_then_poweroff", poweroff, 1);
    repeat (3) step();
    powerGood = 1'b1; nvValid = 1'b1;
    n01 = 0; n10 = 0; k = 0;
    step();
    while (busy && k < 60) begin
      if (poweron == 2'b01) n01++;
      if (poweron == 2'b10) n10++;
      step(); k++;
    end
    check("restore_read_cycles", n01, NUM_REGS);
    check("resume_pulse_cycles", n10, 1);
    check("restore_back_idle", busy, 0);
    powerGood = 1'b0;

    // Cold power-up: no NV image, straight to resume
    powerWarn = 1'b1; k = 0;
    while (!poweroff && k < 60) begin step(); k++; end
    powerWarn = 1'b0; nvValid = 1'b0;
    repeat (2) step();
    check("cold_off_holds", poweroff, 1);
    base_cnt = n_read;
    powerGood = 1'b1;
    step();
    check("cold_resume", poweron, 2'b10);
    step();
    check("cold_idle", busy, 0);
    check("cold_no_nv_read", n_read - base_cnt, 0);
    powerGood = 1'b0;

    // Warning mid-restore
    powerWarn = 1'b1; k = 0;
    while (!poweroff && k < 60) begin step(); k++; end
    powerWarn = 1'b0;
    base_cnt = n_commit;
    powerGood = 1'b1; nvValid = 1'b1; k = 0;
    while (!(poweron == 2'b01 && regIdx == 5) && k < 20) begin step(); k++; end
    check("restore_at_idx5", regIdx, 5);
    powerWarn = 1'b1;
    step();
    check("restore_abort_off", poweroff, 1);
    check("restore_abort_no_read", nvRead, 0);
    powerWarn = 1'b0; powerGood = 1'b0;
    repeat (3) step();
    check("restore_abort_no_commit", n_commit - base_cnt, 0);
    powerGood = 1'b1; nvValid = 1'b0;
    wait_idle("restore_abort_recover", 10);
    powerGood = 1'b0;

    // Slow handshake, then async reset at regIdx 20
    interval = 3;
    for (int i = 0; i < 300; i++) begin
      if (checkpointing && regIdx == 20) break;
      nvAck = (n_edge % 3 == 2);
      prev_idx = regIdx; prev_ack = nvAck; prev_saving = checkpointing;
      step();
      if (prev_saving && checkpointing)
        check("slow_ack_idx", regIdx, prev_ack ? prev_idx + 1 : prev_idx);
    end
    check("slow_reach_idx20", regIdx, 20);
    base_cnt = n_commit;
    #3 reset = 1'b1;
    #1;
    model_clear();
    check("async_reset_outputs", obs_vec(), '0);
    repeat (2) step();
    reset = 1'b0; interval = 0; nvAck = 1'b1;
    repeat (5) step();
    check("reset_no_commit", n_commit - base_cnt, 0);

    // Random traffic against the model
    reset = 1'b1;
    step();
    reset = 1'b0;
    interval = PERIOD_W'($urandom_range(20, 60));
    powerWarn = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) powerWarn = ~powerWarn;
      powerGood = ($urandom_range(0, 3) != 0);
      nvValid   = $urandom_range(0, 1) == 1;
      iStall    = ($urandom_range(0, 5) == 0);
      dStall    = ($urandom_range(0, 5) == 0);
      nvAck     = $urandom_range(0, 1) == 1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tiger_ckpt_ctrl.md
# tiger_ckpt_ctrl

Checkpoint/rollback sequencer for the Tiger MIPS core on intermittent power. It generates the core's `checkpoint`, `checkpointing`, `zstall`, `checkpointdone`, `poweroff` and `poweron[1:0]` controls. It walks the register index through a non-volatile (NV) store for save and restore. Checkpoints are triggered periodically or by a supply-low warning. It sits beside the core top level and the NV store.

## Interface
- `NUM_REGS`, 32: words saved/restored per checkpoint; index width is `$clog2(NUM_REGS)`.
- `PERIOD_W`, 16: width of the periodic-checkpoint interval counter.
- `DRAIN_CYCLES`, 4: consecutive stall-free cycles required before saving.
- `clk` in 1: core clock.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `interval` in PERIOD_W: periodic checkpoint interval in cycles; 0 disables periodic checkpoints.
- `powerWarn` in 1: supply-low warning, level-sensitive.
- `powerGood` in 1: supply restored, level-sensitive.
- `nvValid` in 1: NV store holds a committed checkpoint.
- `iStall`, `dStall` in 1 each: core memory stalls.
- `nvAck` in 1: NV store accepted the current word write or read.
- `checkpoint` out 1: freeze the pipeline for a checkpoint.
- `checkpointing` out 1: register save in progress.
- `zstall` out 1: hold fetch.
- `checkpointdone` out 1: 1-cycle pulse when a checkpoint commits.
- `poweroff` out 1: core powered down.
- `poweron` out 2: 00 = run, 01 = restore in progress, 10 = resume pulse.
- `nvWrite`, `nvRead` out 1 each: NV word request, held until `nvAck`.
- `regIdx` out idx width: register index for the current NV transfer.
- `nvCommit` out 1: 1-cycle pulse that marks the NV image valid.
- `busy` out 1: state is not IDLE.

## Operation
- States and outputs:
  - IDLE: all outputs 0.
  - DRAIN: `checkpoint`=1, `zstall`=1.
  - SAVE: `checkpoint`=1, `checkpointing`=1, `zstall`=1, `nvWrite`=1.
  - COMMIT: `checkpoint`=1, `zstall`=1, `checkpointdone`=1, `nvCommit`=1.
  - OFF: `poweroff`=1, `zstall`=1.
  - RESTORE: `poweron`=01, `zstall`=1, `nvRead`=1.
  - RESUME: `poweron`=10.
- IDLE:
  - `powerWarn`=1 → DRAIN, and `warnLatched` is set.
  - Otherwise, if `interval`≠0 and `intCnt`==`interval`-1 → DRAIN, and `intCnt` clears.
  - Otherwise `intCnt` increments.
  - `powerWarn` has priority over the periodic trigger.
- DRAIN:
  - `drainCnt` increments each cycle with `iStall`=0 and `dStall`=0.
  - `drainCnt` clears on any stall cycle.
  - `drainCnt`==DRAIN_CYCLES-1 on a stall-free cycle → SAVE, with `regIdx`=0.
- SAVE:
  - Each cycle with `nvAck`, `regIdx` increments.
  - `nvAck` at `regIdx`==NUM_REGS-1 → COMMIT.
- COMMIT (one cycle):
  - Next state is OFF if `warnLatched`, else IDLE.
  - `intCnt` clears.
  - `warnLatched` stays set into OFF.
- `powerWarn` rising in DRAIN or SAVE sets `warnLatched`; the save completes and the controller goes to OFF.
- OFF:
  - `powerGood`=1 and `powerWarn`=0 → RESTORE with `regIdx`=0 if `nvValid`, else RESUME.
  - `warnLatched` clears on exit.
- RESTORE:
  - Each `nvAck` increments `regIdx`.
  - `nvAck` at NUM_REGS-1 → RESUME.
  - `powerWarn`=1 → OFF immediately, with no commit; the NV image is untouched.
- RESUME (one cycle) → IDLE, with `intCnt`=0.
- Counters:
  - `intCnt` is PERIOD_W bits.
  - If `interval` changes to a value ≤ `intCnt`, the counter wraps at 2^PERIOD_W and then matches.

## Timing
- Reset (async) → IDLE: every output 0, `regIdx`=0, all counters 0, `warnLatched`=0.
- Reset mid-save discards the partial save; there is no `nvCommit`.
- Outputs are Moore (decoded from registered state); no combinational path from inputs to outputs.
- Trigger to `checkpoint`: 1 cycle.
- Minimum checkpoint length with `nvAck` tied high: 1 + DRAIN_CYCLES + NUM_REGS + 1 cycles from trigger to the `checkpointdone` cycle (38 with defaults).
- `nvWrite`/`nvRead` and `regIdx` are stable until the `nvAck` cycle. `nvAck` while no request is pending is ignored.
- `checkpointdone` and `nvCommit` coincide for exactly 1 cycle.
- `poweron`=10 appears for exactly 1 cycle, then 00.

## Test plan
- Periodic checkpoint: `interval`=100, no stalls, `nvAck`=1:
  - `checkpoint` rises 100 cycles after reset release.
  - `regIdx` counts 0..31.
  - `checkpointdone` pulses 38 cycles after the trigger.
  - Controller returns to IDLE and the next trigger follows 100 cycles later.
- Drain with stalls: `dStall` high for 2 cycles within DRAIN → SAVE entry delayed until 4 consecutive stall-free cycles.
- Warning mid-save: `powerWarn` at `regIdx`=10 → save completes to 31, `checkpointdone` pulses, then `poweroff`=1. Then `powerGood`=1, `nvValid`=1 → `poweron`=01 for 32 acked reads, `poweron`=10 for 1 cycle, then IDLE.
- Cold power-up: OFF with `nvValid`=0 and `powerGood`=1 → RESUME for 1 cycle; no `nvRead` issued.
- Warning mid-restore: `powerWarn` at `regIdx`=5 → OFF next cycle; `nvCommit` never asserted.
- Async reset asserted mid-SAVE at `regIdx`=20 → all outputs 0 without waiting for a clock edge; no `nvCommit`. Handshake slowed with `nvAck` every 3rd cycle → `regIdx` is held between acks.
